bias_seq: RTL and testbench

BIAS_SEQ -- requirements
Module: bias_seq

---
 rtl/bias_seq_if.sv | 46 ++++
 rtl/bias_seq.sv | 171 +++++++++++++++++
 tb/tb_bias_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_seq_if.sv
// Bundle of run-control, ROM read and downstream-FIFO write signals for bias_seq.
// Latency: none, wires only.
// Backpressure: output_V_full_n flows back to the master; the master throttles itself.
interface bias_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 4
);
  // run control
  logic                  ap_start;
  logic                  ap_idle;
  logic                  ap_done;
  // ROM read port
  logic [AW-1:0]         rom_address;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  // downstream FIFO write port
  logic [DATA_WIDTH-1:0] output_V_din;
  logic                  output_V_full_n;
  logic                  output_V_write;

  // sequencer side
  modport master (
    input  ap_start,
    input  rom_q,
    input  output_V_full_n,
    output ap_idle,
    output ap_done,
    output rom_address,
    output rom_ce,
    output output_V_din,
    output output_V_write
  );

  // environment side: controller, ROM and downstream FIFO
  modport slave (
    output ap_start,
    output rom_q,
    output output_V_full_n,
    input  ap_idle,
    input  ap_done,
    input  rom_address,
    input  rom_ce,
    input  output_V_din,
    input  output_V_write
  );
endinterface

// File: rtl/bias_seq.sv
// Streams MEM_SIZE bias words from a ROM, REPEAT passes per run, into a downstream FIFO.
// Latency: first write two cycles after the first RUN cycle, then one word per cycle.
// Backpressure: full_n low stalls the 2-entry output FIFO; ROM reads throttle so no data is dropped.
module bias_seq #(
  parameter int MEM_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int REPEAT     = 64
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  bias_seq_if.master bus
);

  localparam int AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int TOTAL = MEM_SIZE * REPEAT;
  localparam int XW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_idle;
  logic                  w_done;

  // issue side: address within a pass and completed-pass count
  logic [AW-1:0]         r_addr;
  logic [15:0]           r_pass;
  // transfer side: words handed downstream in this run
  logic [XW-1:0]         r_xfer;

  // one-deep pipeline tracking the ROM read latency
  logic                  r_inflight;

  // 2-entry output FIFO kept as head/tail registers so the head
  // keeps its last value once the FIFO drains
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic                  w_run;
  logic                  w_reads_left;
  logic                  w_pop;
  logic                  w_push;
  logic [1:0]            w_occ_after;
  logic                  w_ce;
  logic                  w_last_xfer;

  assign w_run        = (r_state == S_RUN);
  assign w_reads_left = (r_pass != 16'(REPEAT));
  assign w_pop        = (r_cnt != 2'd0) && bus.output_V_full_n && w_run;
  assign w_push       = r_inflight;
  // A slot freed by this cycle's pop can be reused by a read issued now,
  // which is what lets the stream sustain one word per cycle.
  assign w_occ_after  = r_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
  assign w_ce         = w_run && w_reads_left && (w_occ_after < 2'd2);
  assign w_last_xfer  = w_pop && (r_xfer == XW'(TOTAL - 1));

  // State register; reset wins over ap_start.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_idle       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (bus.ap_start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_xfer) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Read address / pass counter and transfer counter; idle restarts at address 0, pass 0.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || (r_state == S_IDLE)) begin
      r_addr <= '0;
      r_pass <= '0;
      r_xfer <= '0;
    end else begin
      if (w_ce) begin
        if (r_addr == AW'(MEM_SIZE - 1)) begin
          r_addr <= '0;
          r_pass <= r_pass + 16'd1;
        end else begin
          r_addr <= r_addr + AW'(1);
        end
      end
      if (w_pop) begin
        r_xfer <= r_xfer + XW'(1);
      end
    end
  end

  // Track the read issued last cycle; reset drops any read still in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ce;
    end
  end

  // Output FIFO: push rom_q the cycle after each read, pop on each transfer, order preserved.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head <= bus.rom_q;
          end else begin
            r_tail <= bus.rom_q;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= bus.rom_q;
          end else begin
            r_head <= r_tail;
            r_tail <= bus.rom_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ap_idle        = w_idle;
  assign bus.ap_done        = w_done;
  assign bus.rom_address    = r_addr;
  assign bus.rom_ce         = w_ce;
  assign bus.output_V_din   = r_head;
  assign bus.output_V_write = w_pop;

endmodule

// File: tb/tb_bias_seq.sv
// Testbench for bias_seq: cycle-exact vector table plus multi-cycle sequences on three configurations.
// Latency: n/a.
// Backpressure: drives output_V_full_n directly (fixed windows and random).
module tb_bias_seq;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  bias_seq_if #(.DATA_WIDTH(16), .AW(2)) if0 ();
  bias_seq_if #(.DATA_WIDTH(16), .AW(1)) if1 ();
  bias_seq_if #(.DATA_WIDTH(16), .AW(2)) if2 ();

  bias_seq #(.MEM_SIZE(4), .DATA_WIDTH(16), .REPEAT(3)) u0 (.ap_clk(clk), .ap_rst(rst), .bus(if0));
  bias_seq #(.MEM_SIZE(1), .DATA_WIDTH(16), .REPEAT(5)) u1 (.ap_clk(clk), .ap_rst(rst), .bus(if1));
  bias_seq #(.MEM_SIZE(3), .DATA_WIDTH(16), .REPEAT(3)) u2 (.ap_clk(clk), .ap_rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: data valid the cycle after rom_ce
  always @(posedge clk) if (if0.rom_ce) if0.rom_q <= 16'(10 * (int'(if0.rom_address) + 1));
  always @(posedge clk) if (if1.rom_ce) if1.rom_q <= 16'd7;
  always @(posedge clk) if (if2.rom_ce) if2.rom_q <= 16'(100 + int'(if2.rom_address));

  // Monitors sample mid-cycle, after the stimulus has settled.
  logic [15:0] got0[$];
  logic [15:0] got1[$];
  logic [15:0] got2[$];
  int          addr2q[$];
  int          wr0 = 0, done0 = 0, viol0 = 0, m_cnt0 = 0, m_infl0 = 0;
  int          done1 = 0, viol1 = 0, done2 = 0, viol2 = 0;

  always @(negedge clk) begin
    int w;
    #2;
    if (rst) begin
      m_cnt0  = 0;
      m_infl0 = 0;
    end else begin
      w = int'(if0.output_V_write);
      if (w == 1) begin
        got0.push_back(if0.output_V_din);
        wr0++;
        if (!if0.output_V_full_n || m_cnt0 == 0) viol0++;
      end
      // occupancy left after this cycle's pop plus the read still in flight
      if (if0.rom_ce && (m_cnt0 - w + m_infl0) >= 2) viol0++;
      if ((m_cnt0 - w + m_infl0) > 2) viol0++;
      if (if0.ap_done) done0++;
      m_cnt0  = m_cnt0 - w + m_infl0;
      m_infl0 = int'(if0.rom_ce);
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (if1.output_V_write) got1.push_back(if1.output_V_din);
      if (if1.rom_address != 1'b0) viol1++;
      if (if1.ap_done) done1++;
      if (if2.output_V_write) got2.push_back(if2.output_V_din);
      if (if2.rom_ce) addr2q.push_back(int'(if2.rom_address));
      if (if2.rom_address == 2'd3) viol2++;
      if (if2.ap_done) done2++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_seq0(input string tag, input int n);
    check({tag, " count"}, got0.size(), n);
    for (int i = 0; i < n && i < got0.size(); i++)
      check($sformatf("%s word%0d", tag, i), int'(got0[i]), 10 * ((i % 4) + 1));
  endtask

  typedef struct {
    logic rst;
    logic start;
    logic full_n;
    logic idle;
    logic done;
    logic ce;
    int   addr;
    logic wr;
    int   din;
  } vec_t;

  vec_t vt[19];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int hold;
    int idle_len;
    bit after_done;
    int ndone;

    // reset rows: row0 also has ap_start high, which reset must override
    for (int i = 0; i < 3; i++) begin
      vt[i].rst    = (i == 0);
      vt[i].start  = (i != 1);
      vt[i].full_n = 1'b1;
      vt[i].idle   = 1'b1;
      vt[i].done   = 1'b0;
      vt[i].ce     = 1'b0;
      vt[i].addr   = 0;
      vt[i].wr     = 1'b0;
      vt[i].din    = 0;
    end
    // basic run: RUN cycles c=0..13, DONE at 14, IDLE at 15
    for (int c = 0; c < 16; c++) begin
      vt[3+c].rst    = 1'b0;
      vt[3+c].start  = 1'b0;
      vt[3+c].full_n = 1'b1;
      vt[3+c].idle   = (c == 15);
      vt[3+c].done   = (c == 14);
      vt[3+c].ce     = (c <= 11);
      vt[3+c].addr   = (c <= 11) ? (c % 4) : 0;
      vt[3+c].wr     = (c >= 2 && c <= 13);
      vt[3+c].din    = (c < 2) ? 0 : ((c <= 13) ? 10 * (((c - 2) % 4) + 1) : 40);
    end

    rst = 1'b1;
    if0.ap_start = 1'b0; if0.output_V_full_n = 1'b1;
    if1.ap_start = 1'b0; if1.output_V_full_n = 1'b1;
    if2.ap_start = 1'b0; if2.output_V_full_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven basic run
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst                 = vt[i].rst;
      if0.ap_start        = vt[i].start;
      if0.output_V_full_n = vt[i].full_n;
      #1;
      check($sformatf("row%0d idle", i),  int'(if0.ap_idle),        int'(vt[i].idle));
      check($sformatf("row%0d done", i),  int'(if0.ap_done),        int'(vt[i].done));
      check($sformatf("row%0d ce", i),    int'(if0.rom_ce),         int'(vt[i].ce));
      check($sformatf("row%0d addr", i),  int'(if0.rom_address),    vt[i].addr);
      check($sformatf("row%0d write", i), int'(if0.output_V_write), int'(vt[i].wr));
      check($sformatf("row%0d din", i),   int'(if0.output_V_din),   vt[i].din);
    end
    @(negedge clk);
    check_seq0("basic", 12);
    check("basic done pulses", done0, 1);

    // back-pressure: full_n low during RUN cycles 5..9
    got0.delete(); done0 = 0;
    found = 0; hold = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if0.ap_start        = (k == 0);
      if0.output_V_full_n = !(k - 1 >= 5 && k - 1 <= 9);
      #1;
      if (k - 1 == 5) hold = int'(if0.output_V_din);
      if (k - 1 > 5 && k - 1 <= 9) check($sformatf("bp din stable c%0d", k - 1), int'(if0.output_V_din), hold);
      if (if0.ap_done) found = 1;
    end
    if0.output_V_full_n = 1'b1;
    check("bp done seen", int'(found), 1);
    @(negedge clk);
    check("bp idle after done", int'(if0.ap_idle), 1);
    check_seq0("bp", 12);
    check("bp done pulses", done0, 1);

    // three back-to-back runs with start held high and random full_n
    got0.delete(); done0 = 0;
    ndone = 0; idle_len = 0; after_done = 0;
    for (int k = 0; k < 600 && ndone < 3; k++) begin
      @(negedge clk);
      if0.ap_start        = 1'b1;
      if0.output_V_full_n = 1'($urandom_range(0, 1));
      #1;
      if (if0.ap_done) begin
        ndone++;
        after_done = 1;
        idle_len   = 0;
      end else if (after_done) begin
        if (if0.ap_idle) idle_len++;
        else begin
          check("rand idle gap", idle_len, 1);
          after_done = 0;
        end
      end
    end
    @(negedge clk);
    if0.ap_start = 1'b0; if0.output_V_full_n = 1'b1;
    check("rand runs completed", ndone, 3);
    repeat (3) @(negedge clk);
    check_seq0("rand", 36);
    check("rand done pulses", done0, 3);

    // reset after the 5th write aborts the run silently
    got0.delete(); done0 = 0; wr0 = 0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if0.ap_start = (k == 0);
      #3;
      if (wr0 >= 5) found = 1;
    end
    check("rst 5 writes seen", int'(found), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst idle",  int'(if0.ap_idle),        1);
    check("rst done",  int'(if0.ap_done),        0);
    check("rst ce",    int'(if0.rom_ce),         0);
    check("rst addr",  int'(if0.rom_address),    0);
    check("rst write", int'(if0.output_V_write), 0);
    check("rst din",   int'(if0.output_V_din),   0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst no done pulse", done0, 0);
    got0.delete();
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if0.ap_start = (k == 0);
      #1;
      if (if0.ap_done) found = 1;
    end
    check("rerun done seen", int'(found), 1);
    @(negedge clk);
    check_seq0("rerun", 12);
    check("rerun done pulses", done0, 1);
    check("dut0 flow violations", viol0, 0);

    // MEM_SIZE=1 and MEM_SIZE=3 configurations
    got1.delete(); got2.delete(); addr2q.delete();
    done1 = 0; done2 = 0;
    for (int k = 0; k < 80 && (done1 == 0 || done2 == 0); k++) begin
      @(negedge clk);
      if1.ap_start = (k == 0);
      if2.ap_start = (k == 0);
      #3;
    end
    repeat (2) @(negedge clk);
    check("m1 done pulses", done1, 1);
    check("m1 count", got1.size(), 5);
    for (int i = 0; i < got1.size(); i++) check($sformatf("m1 word%0d", i), int'(got1[i]), 7);
    check("m1 nonzero address", viol1, 0);
    check("m3 done pulses", done2, 1);
    check("m3 read count", addr2q.size(), 9);
    for (int i = 0; i < addr2q.size(); i++) check($sformatf("m3 addr%0d", i), addr2q[i], i % 3);
    check("m3 address 3 driven", viol2, 0);
    check("m3 count", got2.size(), 9);
    for (int i = 0; i < got2.size(); i++) check($sformatf("m3 word%0d", i), int'(got2[i]), 100 + (i % 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
